// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, synchronous-read BRAM between instruction fetch and the
// load/store unit, and handles store lane steering and load alignment/extension.
module mem_port_arbiter #(
    parameter int AWIDTH       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_func3,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        R_NONE,
        R_IF,
        R_DM
    } resp_t;

    resp_t         state_p1;
    resp_t         state_nxt;
    logic [SW-1:0] streak;
    logic          starved;
    logic [1:0]    lane;
    logic [3:0]    st_we;
    logic [31:0]   st_din;
    logic          st_err;
    logic          ld_err;
    logic          acc_err;
    logic [2:0]    func3_p1;
    logic [1:0]    lane_p1;
    logic          we_p1;
    logic          err_p1;
    logic [31:0]   dm_load;
    logic [31:0]   if_data_q;
    logic [31:0]   dm_rdata_q;
    logic          unused_addr_bits;

    // Select the addressed byte/half of a read word and extend it per the RV32I load code.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> {a, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'd0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'd0, h};
            3'b010:  load_extend = word;
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign lane    = dm_addr[1:0];
    assign starved = (streak == STREAK_MAX);

    // Grants are masked while reset is held so nothing new is registered during reset.
    assign if_gnt = !rst && if_req && (!dm_req || starved);
    assign dm_gnt = !rst && dm_req && !(if_req && starved);

    always_comb begin
        st_we  = 4'b0000;
        st_din = dm_wdata;
        st_err = 1'b0;
        case (dm_func3)
            3'b000: begin
                st_we  = 4'b0001 << lane;
                st_din = {4{dm_wdata[7:0]}};
            end
            3'b001: begin
                st_we  = 4'b0011 << lane;
                st_din = {2{dm_wdata[15:0]}};
                st_err = lane[0];
            end
            3'b010: begin
                st_we  = 4'b1111;
                st_err = (lane != 2'b00);
            end
            default: st_err = 1'b1;
        endcase
        if (st_err) begin
            st_we = 4'b0000;
        end
    end

    always_comb begin
        case (dm_func3)
            3'b000, 3'b100: ld_err = 1'b0;
            3'b001, 3'b101: ld_err = lane[0];
            3'b010:         ld_err = (lane != 2'b00);
            default:        ld_err = 1'b1;
        endcase
    end

    assign acc_err = dm_we ? st_err : ld_err;

    assign mem_en   = if_gnt | dm_gnt;
    assign mem_addr = dm_gnt ? dm_addr[AWIDTH+1:2] : if_addr[AWIDTH+1:2];
    assign mem_we   = (dm_gnt && dm_we) ? st_we : 4'b0000;
    assign mem_din  = (dm_gnt && dm_we) ? st_din : 32'd0;

    assign unused_addr_bits = ^{if_addr[31:AWIDTH+2], if_addr[1:0], dm_addr[31:AWIDTH+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (!if_req || if_gnt) begin
            streak <= '0;
        end else if (dm_gnt && !starved) begin
            streak <= streak + 1'b1;
        end
    end

    // ---- p1: grant registered, BRAM read in flight ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= R_NONE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (dm_gnt) begin
            func3_p1 <= dm_func3;
            lane_p1  <= lane;
            we_p1    <= dm_we;
            err_p1   <= acc_err;
        end
    end

    assign dm_load = (we_p1 || err_p1) ? 32'd0 : load_extend(func3_p1, lane_p1, mem_dout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_data_q  <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            if (state_p1 == R_IF) begin
                if_data_q <= mem_dout;
            end
            if (state_p1 == R_DM) begin
                dm_rdata_q <= dm_load;
            end
        end
    end

    always_comb begin
        state_nxt = R_NONE;
        if_valid  = 1'b0;
        if_data   = if_data_q;
        dm_valid  = 1'b0;
        dm_err    = 1'b0;
        dm_rdata  = dm_rdata_q;
        if (if_gnt) begin
            state_nxt = R_IF;
        end else if (dm_gnt) begin
            state_nxt = R_DM;
        end
        case (state_p1)
            R_IF: begin
                if_valid = 1'b1;
                if_data  = mem_dout;
            end
            R_DM: begin
                dm_valid = 1'b1;
                dm_err   = err_p1;
                dm_rdata = dm_load;
            end
            default: ;
        endcase
    end

endmodule
